// File: rtl/game_frame_handoff.sv
// rtl/game_frame_handoff.sv - tear-free game-state handoff into the VGA display register
//
// Purpose: stage the most recent complete game state from the game logic and
// promote it to VGA_frame only on the rising edge of VGA_new_frame_ready, so
// game_decoder renders one stable state for a whole frame.
//
// Optional feature macro: FRAME_HANDOFF_STATS_EN (adds dropped_count / repeat_count).
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   game_state_valid/in   - offered game state from the game logic
//   game_state_ready      - accept indication (0 while reset is high)
//   VGA_new_frame_ready   - vsync level; rising edge opens a swap window
//   VGA_frame             - display state for game_decoder
//   frame_swapped         - one-cycle pulse, first cycle a new VGA_frame is visible
//   frame_count           - number of promotions (wraps)
//   dropped_count         - staged states lost to overwrite (saturating, macro only)
//   repeat_count          - windows that found nothing staged (saturating, macro only)

package game_state_pkg;
  typedef struct packed {
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_l;
    logic [9:0] paddle_r;
    logic [7:0] score;
  } game_state_t;
endpackage

module game_frame_handoff #(
  parameter bit OVERWRITE         = 1'b1,
  parameter int FRAME_COUNT_WIDTH = 16,
  parameter int STAT_COUNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          game_state_valid,
  input  game_state_pkg::game_state_t   game_state_in,
  output logic                          game_state_ready,
  input  logic                          VGA_new_frame_ready,
  output game_state_pkg::game_state_t   VGA_frame,
  output logic                          frame_swapped,
  output logic [FRAME_COUNT_WIDTH-1:0]  frame_count
`ifdef FRAME_HANDOFF_STATS_EN
  ,
  output logic [STAT_COUNT_WIDTH-1:0]   dropped_count,
  output logic [STAT_COUNT_WIDTH-1:0]   repeat_count
`endif
);

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_STAGED = 1'b1
  } state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  game_state_pkg::game_state_t    r_staged;
  game_state_pkg::game_state_t    r_frame;
  logic                           r_nfr_q;
  logic                           r_swapped;
  logic [FRAME_COUNT_WIDTH-1:0]   r_frame_count;

  logic w_ready;
  logic w_accept;
  logic w_win;
  logic w_promote;

  // Next-state and handshake decode. Ready depends only on reset and the
  // state register, never on game_state_valid.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_promote    = 1'b0;
    w_win        = VGA_new_frame_ready & ~r_nfr_q;
    if (!reset) begin
      w_ready = OVERWRITE ? 1'b1 : (r_state == ST_EMPTY);
    end
    w_accept = game_state_valid & w_ready;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) w_state_next = ST_STAGED;
      end
      ST_STAGED: begin
        w_promote = w_win;
        // A same-cycle accept refills the slot the promotion just emptied.
        if (w_win && !w_accept) w_state_next = ST_EMPTY;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath. nfr_q resets high so a reset released during vsync needs a
  // fresh rising edge before any window opens.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nfr_q       <= 1'b1;
      r_staged      <= '0;
      r_frame       <= '0;
      r_swapped     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_nfr_q   <= VGA_new_frame_ready;
      r_swapped <= w_promote;
      if (w_accept) r_staged <= game_state_in;
      // Promotion reads the pre-edge staged value, so an incoming state
      // never bypasses straight to the display.
      if (w_promote) begin
        r_frame       <= r_staged;
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign game_state_ready = w_ready;
  assign VGA_frame        = r_frame;
  assign frame_swapped    = r_swapped;
  assign frame_count      = r_frame_count;

`ifdef FRAME_HANDOFF_STATS_EN
  logic                          w_drop;
  logic                          w_repeat;
  logic [STAT_COUNT_WIDTH-1:0]   r_dropped;
  logic [STAT_COUNT_WIDTH-1:0]   r_repeat;

  assign w_drop   = w_accept & (r_state == ST_STAGED) & ~w_win;
  assign w_repeat = w_win & (r_state == ST_EMPTY);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dropped <= '0;
      r_repeat  <= '0;
    end else begin
      if (w_drop && (r_dropped != '1))  r_dropped <= r_dropped + 1'b1;
      if (w_repeat && (r_repeat != '1)) r_repeat  <= r_repeat + 1'b1;
    end
  end

  assign dropped_count = r_dropped;
  assign repeat_count  = r_repeat;
`endif

endmodule

// File: tb/tb_game_frame_handoff.sv
// tb/tb_game_frame_handoff.sv - self-checking bench for game_frame_handoff
module tb_game_frame_handoff;
  import game_state_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // u1: OVERWRITE=1, u0: OVERWRITE=0, u2: 2-bit statistics counters
  logic v1, nfr1, rdy1, sw1; game_state_t d1, f1; logic [15:0] fc1;
  logic v0, nfr0, rdy0, sw0; game_state_t d0, f0; logic [15:0] fc0;
  logic v2, nfr2, rdy2, sw2; game_state_t d2, f2; logic [15:0] fc2;
`ifdef FRAME_HANDOFF_STATS_EN
  logic [15:0] dc1, rc1, dc0, rc0;
  logic [1:0]  dc2, rc2;
`endif

  game_frame_handoff #(.OVERWRITE(1'b1)) u1 (
    .clk(clk), .reset(reset), .game_state_valid(v1), .game_state_in(d1),
    .game_state_ready(rdy1), .VGA_new_frame_ready(nfr1), .VGA_frame(f1),
    .frame_swapped(sw1), .frame_count(fc1)
`ifdef FRAME_HANDOFF_STATS_EN
    , .dropped_count(dc1), .repeat_count(rc1)
`endif
  );

  game_frame_handoff #(.OVERWRITE(1'b0)) u0 (
    .clk(clk), .reset(reset), .game_state_valid(v0), .game_state_in(d0),
    .game_state_ready(rdy0), .VGA_new_frame_ready(nfr0), .VGA_frame(f0),
    .frame_swapped(sw0), .frame_count(fc0)
`ifdef FRAME_HANDOFF_STATS_EN
    , .dropped_count(dc0), .repeat_count(rc0)
`endif
  );

  game_frame_handoff #(.OVERWRITE(1'b1), .STAT_COUNT_WIDTH(2)) u2 (
    .clk(clk), .reset(reset), .game_state_valid(v2), .game_state_in(d2),
    .game_state_ready(rdy2), .VGA_new_frame_ready(nfr2), .VGA_frame(f2),
    .frame_swapped(sw2), .frame_count(fc2)
`ifdef FRAME_HANDOFF_STATS_EN
    , .dropped_count(dc2), .repeat_count(rc2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic game_state_t mk(input int k);
    game_state_t s;
    s.ball_x   = 10'(k * 3 + 1);
    s.ball_y   = 10'(k * 5 + 2);
    s.paddle_l = 10'(k + 7);
    s.paddle_r = 10'(k * 11);
    s.score    = 8'(k);
    return s;
  endfunction

  // Scoreboard for u1: an independent model of staging pushes the state that
  // must appear on VGA_frame whenever a window meets a staged state.
  game_state_t sb_q[$];
  game_state_t m_staged;
  logic        m_valid, m_nfrq;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_valid = 1'b0; m_nfrq = 1'b1; m_cnt = '0; m_staged = '0;
  endtask

  task automatic drive1(input logic v, input game_state_t d, input logic nfr);
    logic win, prom;
    v1 = v; d1 = d; nfr1 = nfr;
    win  = nfr & ~m_nfrq;
    prom = win & m_valid;
    if (prom) sb_q.push_back(m_staged);
    if (v) begin
      m_staged = d; m_valid = 1'b1;
    end else if (prom) begin
      m_valid = 1'b0;
    end
    m_nfrq = nfr;
  endtask

  always @(negedge clk) begin
    if (!reset && sw1) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected_swap: got frame %0h expected no swap", f1);
      end else begin
        game_state_t e;
        e = sb_q.pop_front();
        m_cnt = m_cnt + 16'd1;
        chk("sb_frame", 64'(f1), 64'(e));
        chk("sb_count", 64'(fc1), 64'(m_cnt));
      end
    end
  end

  typedef struct {
    logic        v;
    game_state_t d;
    logic        nfr;
    logic        exp_sw;
    game_state_t exp_frame;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic v, input game_state_t d, input logic nfr,
                              input logic sw, input game_state_t fr, input logic [15:0] c);
    vec_t r;
    r.v = v; r.d = d; r.nfr = nfr; r.exp_sw = sw; r.exp_frame = fr; r.exp_cnt = c;
    tbl.push_back(r);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  game_state_t A, A2, B2, C2, D, E, Z;

  initial begin
    A = mk(1); A2 = mk(2); B2 = mk(3); C2 = mk(4); D = mk(5); E = mk(6); Z = '0;

    // Reset asserted during vsync; vsync stays high after release.
    reset = 1'b1;
    v1 = 0; d1 = Z; nfr1 = 1'b1;
    v0 = 0; d0 = Z; nfr0 = 1'b0;
    v2 = 0; d2 = Z; nfr2 = 1'b0;
    repeat (3) tick();
    chk("reset_ready1", 64'(rdy1), 64'(0));
    chk("reset_ready0", 64'(rdy0), 64'(0));
    chk("reset_frame", 64'(f1), 64'(0));
    chk("reset_count", 64'(fc1), 64'(0));
    chk("reset_swapped", 64'(sw1), 64'(0));
    reset = 1'b0;
    model_reset();
    #1;
    chk("ready1_after_reset", 64'(rdy1), 64'(1));
    chk("ready0_after_reset", 64'(rdy0), 64'(1));

    // Table for u1.
    for (int i = 0; i < 10; i++) add(0, Z, 1, 0, Z, 0);
    add(1, A, 0, 0, Z, 0);
    add(0, Z, 1, 1, A, 1);
    add(0, Z, 1, 0, A, 1);
    add(0, Z, 0, 0, A, 1);
    add(1, A2, 0, 0, A, 1);
    add(1, B2, 0, 0, A, 1);
    add(1, C2, 0, 0, A, 1);
    add(1, D, 1, 1, C2, 2);
    add(0, Z, 1, 0, C2, 2);
    add(0, Z, 0, 0, C2, 2);
    add(0, Z, 1, 1, D, 3);
    for (int i = 0; i < 3; i++) begin
      add(0, Z, 0, 0, D, 3);
      add(0, Z, 1, 0, D, 3);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      drive1(tbl[i].v, tbl[i].d, tbl[i].nfr);
      tick();
      if (sw1 !== tbl[i].exp_sw || f1 !== tbl[i].exp_frame || fc1 !== tbl[i].exp_cnt) begin
        n_cmp++; n_bad++;
        $display("FAIL vec%0d: got sw=%0b frame=%0h cnt=%0d expected sw=%0b frame=%0h cnt=%0d",
                 i, sw1, f1, fc1, tbl[i].exp_sw, tbl[i].exp_frame, tbl[i].exp_cnt);
      end else begin
        n_cmp++;
      end
    end
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
`ifdef FRAME_HANDOFF_STATS_EN
    chk("dropped_count", 64'(dc1), 64'(2));
    chk("repeat_count", 64'(rc1), 64'(3));
`endif

    // Reset mid-operation discards both staged and display state.
    drive1(1, E, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("midreset_frame", 64'(f1), 64'(0));
    chk("midreset_count", 64'(fc1), 64'(0));
    chk("midreset_ready", 64'(rdy1), 64'(0));
    reset = 1'b0;
    model_reset();
    drive1(0, Z, 0);
    tick();
    drive1(0, Z, 1);
    tick();
    chk("midreset_no_swap", 64'(sw1), 64'(0));
    chk("midreset_frame_kept0", 64'(f1), 64'(0));
    drive1(0, Z, 0);

    // OVERWRITE=0 back-pressure.
    v0 = 1; d0 = A;
    tick();
    chk("bp_ready_low", 64'(rdy0), 64'(0));
    d0 = B2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_ready", 64'(rdy0), 64'(0));
    end
    nfr0 = 1;
    tick();
    chk("bp_frame_A", 64'(f0), 64'(A));
    chk("bp_swapped", 64'(sw0), 64'(1));
    chk("bp_ready_high", 64'(rdy0), 64'(1));
    tick();
    chk("bp_B_accepted", 64'(rdy0), 64'(0));
    chk("bp_swap_one_cycle", 64'(sw0), 64'(0));
    v0 = 0; nfr0 = 0;
    tick();
    nfr0 = 1;
    tick();
    chk("bp_frame_B", 64'(f0), 64'(B2));
    chk("bp_count", 64'(fc0), 64'(2));

    // Five empty windows on the 2-bit statistics instance.
    for (int i = 0; i < 5; i++) begin
      nfr2 = 0; tick();
      nfr2 = 1; tick();
      chk("sat_no_swap", 64'(sw2), 64'(0));
    end
    chk("sat_frame", 64'(f2), 64'(0));
    chk("sat_count", 64'(fc2), 64'(0));
`ifdef FRAME_HANDOFF_STATS_EN
    chk("sat_repeat", 64'(rc2), 64'(3));
    chk("sat_dropped", 64'(dc2), 64'(0));
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_frame_handoff.md
# game_frame_handoff

Tear-free handoff stage between the game logic and `game_decoder`. It accepts complete game states from the game logic over a valid/ready handshake and holds the most recent one in a staging register. It promotes that state to the display register `VGA_frame` only at the start of a vertical-sync window, signalled by a rising edge of `VGA_new_frame_ready`. `game_decoder` therefore always renders a single, stable state for a whole frame.

## Interface
- `OVERWRITE`, 1: 1 = a newer state replaces an unpromoted staged state (latest wins); 0 = back-pressure while a state is staged.
- `FRAME_COUNT_WIDTH`, 16: width of `frame_count`.
- `STAT_COUNT_WIDTH`, 16: width of the statistics counters (only when `FRAME_HANDOFF_STATS_EN` is defined).

Ports:
- `clk`  in  1  system clock; the block uses this single clock.
- `reset`  in  1  synchronous, active-high reset.
- `game_state_valid`  in  1  game logic offers `game_state_in`.
- `game_state_in`  in  `game_state_pkg::game_state_t`  complete game state.
- `game_state_ready`  out  1  the block accepts this cycle if `valid` is also high.
- `VGA_new_frame_ready`  in  1  high during vsync; its rising edge opens a swap window.
- `VGA_frame`  out  `game_state_pkg::game_state_t`  display state consumed by `game_decoder`.
- `frame_swapped`  out  1  one-cycle pulse, coincident with the first cycle a new `VGA_frame` is visible.
- `frame_count`  out  `FRAME_COUNT_WIDTH`  number of promotions; wraps modulo 2^`FRAME_COUNT_WIDTH`.
- `dropped_count`  out  `STAT_COUNT_WIDTH`  staged states discarded by overwrite (only when `FRAME_HANDOFF_STATS_EN` is defined).
- `repeat_count`  out  `STAT_COUNT_WIDTH`  swap windows that found nothing staged (only when `FRAME_HANDOFF_STATS_EN` is defined).

## Operation
- Storage:
  - `staged` register plus `staged_valid` flag.
  - Display register `VGA_frame`.
  - `nfr_q`, the registered copy of `VGA_new_frame_ready`.
- State machine on `staged_valid`: EMPTY (0) / STAGED (1).
- Ready:
  - `OVERWRITE=1`: `game_state_ready` is constant 1 outside reset.
  - `OVERWRITE=0`: `game_state_ready = ~staged_valid`, combinational from the register only, with no path from `valid`.
- Accept when `accept = game_state_valid & game_state_ready`. On accept, `staged <= game_state_in` and `staged_valid <= 1`.
- Window: `win = VGA_new_frame_ready & ~nfr_q`. This is exactly one cycle per vsync assertion; a level held high never retriggers.
- Promote when `promote = win & staged_valid`, using the pre-edge `staged_valid`. On promote:
  - `VGA_frame <= staged`.
  - `frame_count` increments.
  - `frame_swapped <= 1`.
  - `staged_valid` clears unless `accept` occurs in the same cycle.
- Simultaneous accept and promote: the old staged value goes to the display and the incoming value becomes staged. No drop is counted. The incoming value never bypasses straight to `VGA_frame`.
- Accept while STAGED and not promoting (`OVERWRITE=1` only): `staged` is replaced and `dropped_count` increments.
- Window while EMPTY: `VGA_frame` is unchanged, `frame_swapped` stays 0, and `repeat_count` increments.
- Statistics counters saturate at all-ones; `frame_count` wraps.
- Transitions:
  - EMPTY→STAGED on accept.
  - STAGED→EMPTY on promote without accept.
  - STAGED→STAGED on promote with accept, or on overwrite.

## Timing
- Reset values:
  - `VGA_frame`, `staged` = '0.
  - `staged_valid` = 0, `frame_swapped` = 0, `frame_count` = 0.
  - Statistics counters = 0.
  - `game_state_ready` = 0 while `reset` is high.
  - `nfr_q` = 1, so a reset asserted during vsync cannot produce a false window; the first promotion needs a fresh rising edge.
- Accept-to-staged latency: 1 cycle.
- Window-to-display latency: `VGA_frame` changes at the clock edge that samples `win`. It is valid in the next cycle, together with `frame_swapped=1` and the incremented `frame_count`.
- `VGA_frame` is constant at every other cycle, including across accepts and overwrites.
- `reset` mid-operation discards the staged state and the display state in the same edge; no partial update is permitted.

## Configuration
- `FRAME_HANDOFF_STATS_EN` defined:
  - `dropped_count` and `repeat_count` ports and their saturating counters exist as described.
- Not defined:
  - The ports are absent.
  - No counter logic is generated.
  - All other behaviour is identical.

## Test plan
- Reset while `VGA_new_frame_ready`=1, then release and hold it at 1 for 10 cycles -> no `frame_swapped`; `VGA_frame`=0; `frame_count`=0.
- `OVERWRITE=1`: accept state A, then raise `VGA_new_frame_ready` -> one cycle later `VGA_frame`=A, `frame_swapped`=1 for exactly 1 cycle, `frame_count`=1.
- `OVERWRITE=1`: accept A, B, C on consecutive cycles before the window -> `VGA_frame`=C after the window; `dropped_count`=2.
- Accept D in the same cycle as a window with C staged -> `VGA_frame`=C, `staged`=D; the next window shows D; `frame_count` increases by 2.
- `OVERWRITE=0`: accept A -> `game_state_ready`=0; hold valid with B for 5 cycles -> A is kept; after the window `ready`=1 and B is accepted 1 cycle later.
- Three windows with nothing staged -> `VGA_frame` unchanged; `repeat_count`=3. With `STAT_COUNT_WIDTH`=2, five such windows -> `repeat_count`=3 (saturated).
